rom_burst_reader: RTL and testbench

- Parametrised successor to the 8x16 asynchronous ROM.
- Holds a constant ROM of 2^ADDR_W words of DATA_W bits and serves burst read requests over a valid/ready request channel.
- Returns data on a valid/ready stream with a registered output, last-beat flag, full throughput and backpressure.
- Sits between a control sequencer (issuing requests) and any table consumer such as coefficient or microcode fetch.

---
 rtl/rom_burst_pkg.sv | 20 ++
 rtl/rom_burst_reader_rom.sv | 25 ++
 rtl/rom_burst_reader.sv | 119 +++++++++++
 tb/tb_rom_burst_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_burst_pkg.sv
// Shared types and helpers for the burst-reading constant ROM.
// The ROM contents are generated by multiplying the address by a constant.
package rom_burst_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam logic [63:0] DEFAULT_ROM_MULT = 64'h1111;

    // Content generator; callers truncate to the word width they need.
    function automatic logic [63:0] rom_word(
        input logic [63:0] addr,
        input logic [63:0] mult
    );
        return addr * mult;
    endfunction

endpackage

// File: rtl/rom_burst_reader_rom.sv
// Constant ROM of 2^ADDR_W words with a purely combinational read port.
// Each word is built at elaboration time from the package generator.
module rom_array
    import rom_burst_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 3,
    parameter logic [63:0] ROM_MULT = DEFAULT_ROM_MULT
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [63:0] W = rom_word(64'(i), ROM_MULT);
        assign mem[i] = W[DATA_W-1:0];
    end

    assign data_o = mem[addr_i];

endmodule

// File: rtl/rom_burst_reader.sv
// Serves burst reads from a constant ROM over valid/ready channels.
// A registered output stage delivers one beat per cycle with backpressure.
module rom_burst_reader
    import rom_burst_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 3,
    parameter int          LEN_W    = 4,
    parameter logic [63:0] ROM_MULT = DEFAULT_ROM_MULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cursor_q, cursor_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;

    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic               beat_taken;

    // One read port: the start address while idle, the cursor while streaming.
    assign rom_addr = (state_q == IDLE) ? req_addr : cursor_q;

    rom_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ROM_MULT (ROM_MULT)
    ) u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    assign beat_taken = rd_valid_q && rd_ready;

    // Next-state and output-register update for the IDLE/STREAM sequencer.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        remaining_d = remaining_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_data_d   = rom_data;
                    rd_valid_d  = 1'b1;
                    rd_last_d   = (req_len == '0);
                    cursor_d    = req_addr + ADDR_W'(1);
                    remaining_d = req_len;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    state_d    = IDLE;
                end else if (beat_taken) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        state_d    = IDLE;
                    end else if (remaining_q != '0) begin
                        rd_data_d   = rom_data;
                        cursor_d    = cursor_q + ADDR_W'(1);
                        remaining_d = remaining_q - LEN_W'(1);
                        rd_last_d   = (remaining_q == LEN_W'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cursor_q    <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == STREAM);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed self-checking bench for rom_burst_reader.
// Each task drives one scenario and compares against hand-computed values.
module tb_rom_burst_reader;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_addr;
    logic [3:0]  req_len;
    logic        abort;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        busy;

    int tests;
    int fails;

    rom_burst_reader dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .abort     (abort),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++;
        if ({rd_valid, rd_last, busy, req_ready, rd_data} !== {4'b0001, 16'h0000}) begin
            fails++;
            $display("FAIL reset: got v=%b l=%b busy=%b rdy=%b d=%h, want v=0 l=0 busy=0 rdy=1 d=0000",
                     rd_valid, rd_last, busy, req_ready, rd_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 1'b1;
        req_addr  = 3'd1;
        req_len   = 4'd0;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        tests++;
        if ({rd_valid, rd_last, busy, req_ready, rd_data} !== {4'b1110, 16'h1111}) begin
            fails++;
            $display("FAIL single_beat: got v=%b l=%b busy=%b rdy=%b d=%h, want v=1 l=1 busy=1 rdy=0 d=1111",
                     rd_valid, rd_last, busy, req_ready, rd_data);
        end
        step();
        tests++;
        if ({rd_valid, rd_last, busy, req_ready, rd_data} !== {4'b0001, 16'h1111}) begin
            fails++;
            $display("FAIL single_done: got v=%b l=%b busy=%b rdy=%b d=%h, want v=0 l=0 busy=0 rdy=1 d=1111",
                     rd_valid, rd_last, busy, req_ready, rd_data);
        end
    endtask

    task automatic test_full_rate();
        logic [15:0] exp [4];
        exp[0] = 16'h6666;
        exp[1] = 16'h7777;
        exp[2] = 16'h0000;
        exp[3] = 16'h1111;
        req_valid = 1'b1;
        req_addr  = 3'd6;
        req_len   = 4'd3;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == 3), exp[i]}) begin
                fails++;
                $display("FAIL burst_beat%0d: got v=%b l=%b d=%h, want v=1 l=%b d=%h",
                         i, rd_valid, rd_last, rd_data, (i == 3), exp[i]);
            end
            step();
        end
        tests++;
        if ({rd_valid, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL burst_end: got v=%b rdy=%b, want v=0 rdy=1", rd_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp [3];
        exp[0] = 16'h0000;
        exp[1] = 16'h1111;
        exp[2] = 16'h2222;
        req_valid = 1'b1;
        req_addr  = 3'd0;
        req_len   = 4'd2;
        rd_ready  = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({rd_valid, rd_last, rd_data} !== {2'b10, 16'h0000}) begin
                fails++;
                $display("FAIL stall%0d: got v=%b l=%b d=%h, want v=1 l=0 d=0000",
                         i, rd_valid, rd_last, rd_data);
            end
            step();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == 2), exp[i]}) begin
                fails++;
                $display("FAIL bp_beat%0d: got v=%b l=%b d=%h, want v=1 l=%b d=%h",
                         i, rd_valid, rd_last, rd_data, (i == 2), exp[i]);
            end
            step();
        end
        tests++;
        if ({rd_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL bp_end: got v=%b busy=%b, want v=0 busy=0", rd_valid, busy);
        end
    endtask

    task automatic test_abort();
        logic [15:0] exp [3];
        exp[0] = 16'h2222;
        exp[1] = 16'h3333;
        exp[2] = 16'h4444;
        req_valid = 1'b1;
        req_addr  = 3'd2;
        req_len   = 4'd7;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({rd_valid, rd_last, rd_data} !== {2'b10, exp[i]}) begin
                fails++;
                $display("FAIL abort_beat%0d: got v=%b l=%b d=%h, want v=1 l=0 d=%h",
                         i, rd_valid, rd_last, rd_data, exp[i]);
            end
            if (i == 2) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        tests++;
        if ({rd_valid, rd_last, busy, req_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL abort_end: got v=%b l=%b busy=%b rdy=%b, want v=0 l=0 busy=0 rdy=1",
                     rd_valid, rd_last, busy, req_ready);
        end
        step();
        tests++;
        if ({rd_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL abort_quiet: got v=%b busy=%b, want v=0 busy=0", rd_valid, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 1'b1;
        req_addr  = 3'd3;
        req_len   = 4'd3;
        rd_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        tests++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h3333}) begin
            fails++;
            $display("FAIL rstmid_first: got v=%b d=%h, want v=1 d=3333", rd_valid, rd_data);
        end
        step();
        tests++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h4444}) begin
            fails++;
            $display("FAIL rstmid_second: got v=%b d=%h, want v=1 d=4444", rd_valid, rd_data);
        end
        rd_ready = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({rd_valid, rd_last, busy, req_ready, rd_data} !== {4'b0001, 16'h0000}) begin
            fails++;
            $display("FAIL rstmid_state: got v=%b l=%b busy=%b rdy=%b d=%h, want v=0 l=0 busy=0 rdy=1 d=0000",
                     rd_valid, rd_last, busy, req_ready, rd_data);
        end
        rd_ready = 1'b1;
        step();
        tests++;
        if ({rd_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_quiet: got v=%b busy=%b, want v=0 busy=0", rd_valid, busy);
        end
        req_valid = 1'b1;
        req_addr  = 3'd5;
        req_len   = 4'd0;
        step();
        req_valid = 1'b0;
        tests++;
        if ({rd_valid, rd_last, rd_data} !== {2'b11, 16'h5555}) begin
            fails++;
            $display("FAIL rstmid_newreq: got v=%b l=%b d=%h, want v=1 l=1 d=5555",
                     rd_valid, rd_last, rd_data);
        end
        step();
    endtask

    task automatic test_req_during_stream();
        logic [15:0] exp [3];
        exp[0] = 16'h4444;
        exp[1] = 16'h5555;
        exp[2] = 16'h6666;
        req_valid = 1'b1;
        req_addr  = 3'd4;
        req_len   = 4'd2;
        rd_ready  = 1'b1;
        step();
        req_addr = 3'd7;
        req_len  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({req_ready, rd_valid, rd_last, rd_data} !== {2'b01, (i == 2), exp[i]}) begin
                fails++;
                $display("FAIL hold_beat%0d: got rdy=%b v=%b l=%b d=%h, want rdy=0 v=1 l=%b d=%h",
                         i, req_ready, rd_valid, rd_last, rd_data, (i == 2), exp[i]);
            end
            step();
        end
        tests++;
        if ({req_ready, rd_valid} !== 2'b10) begin
            fails++;
            $display("FAIL hold_idle: got rdy=%b v=%b, want rdy=1 v=0", req_ready, rd_valid);
        end
        step();
        req_valid = 1'b0;
        tests++;
        if ({rd_valid, rd_last, rd_data} !== {2'b11, 16'h7777}) begin
            fails++;
            $display("FAIL hold_accept: got v=%b l=%b d=%h, want v=1 l=1 d=7777",
                     rd_valid, rd_last, rd_data);
        end
        step();
        step();
        tests++;
        if ({rd_valid, busy, req_ready} !== 3'b001) begin
            fails++;
            $display("FAIL hold_once: got v=%b busy=%b rdy=%b, want v=0 busy=0 rdy=1",
                     rd_valid, busy, req_ready);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        abort     = 1'b0;
        rd_ready  = 1'b0;
        test_reset();
        test_single();
        test_full_rate();
        test_backpressure();
        test_abort();
        test_reset_mid_burst();
        test_req_during_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
